// File: rtl/dreimann_pkg.sv
// Shared definitions for the two-dice roller: FSM states, LFSR constants,
// die width and the small helpers used by the datapath.
package dreimann_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ROLL   = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  localparam int          DIE_W     = 3;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Right-shifting Galois form of taps 16,14,13,11.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Fold a 3-bit random value onto a die face 1..6 (6->1, 7->2).
  function automatic logic [DIE_W-1:0] face_map(input logic [2:0] v);
    return (v < 3'd6) ? (v + 3'd1) : (v - 3'd5);
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Roll-button conditioning: 2-FF synchronizer followed by an optional
// stability counter. With DICE_DEBOUNCE_EN defined the output level only
// follows the synchronized input after DEBOUNCE_CYCLES consecutive samples
// of the new value; otherwise the synchronized input is the level.
module btn_debounce #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level
);

  logic meta_reg;
  logic sync_reg;

  // Two-stage synchronizer for the asynchronous button.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= btn;
      sync_reg <= meta_reg;
    end
  end

`ifdef DICE_DEBOUNCE_EN
  logic        level_reg;
  logic [15:0] count_reg;

  // Accept a new level once it has been seen for DEBOUNCE_CYCLES samples in a row.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_reg <= 1'b0;
      count_reg <= 16'd0;
    end else if (sync_reg == level_reg) begin
      count_reg <= 16'd0;
    end else if (count_reg >= DEBOUNCE_CYCLES - 16'd1) begin
      level_reg <= sync_reg;
      count_reg <= 16'd0;
    end else begin
      count_reg <= count_reg + 16'd1;
    end
  end

  assign level = level_reg;
`else
  // Bypass build: the parameter is kept so both builds share one interface.
  if (DEBOUNCE_CYCLES == 16'd0) begin : g_no_debounce_window
  end

  assign level = sync_reg;
`endif

endmodule

// File: rtl/dice_roll_ctrl.sv
// Two-dice roll controller. A debounced button press starts tumbling; dice
// are redrawn from a free-running LFSR every TUMBLE_DIV cycles, keep
// tumbling for SETTLE_TICKS updates after release, then the result flags
// are latched with a one-cycle result_valid_o pulse.
// Build option: DICE_DEBOUNCE_EN enables the button debounce counter.
module dice_roll_ctrl
  import dreimann_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [15:0] TUMBLE_DIV      = 16'd2500,
  parameter logic [7:0]  SETTLE_TICKS    = 8'd12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_i,
  output logic [DIE_W-1:0] die_a_o,
  output logic [DIE_W-1:0] die_b_o,
  output logic [3:0]       sum_o,
  output logic             drei_o,
  output logic             double_o,
  output logic             rolling_o,
  output logic             result_valid_o
);

  logic             level;
  logic             level_prev_reg;
  logic             btn_rise;
  state_t           state_reg, state_next;
  logic [15:0]      div_reg, div_next;
  logic [7:0]       settle_reg, settle_next;
  logic [15:0]      lfsr_reg;
  logic [DIE_W-1:0] die_a_reg, die_a_next;
  logic [DIE_W-1:0] die_b_reg, die_b_next;
  logic [3:0]       sum_reg;
  logic             drei_reg, double_reg, valid_reg;
  logic             tick, settle_done, finish;
  logic             rolling;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_i),
    .level (level)
  );

  assign btn_rise    = level & ~level_prev_reg;
  assign tick        = (div_reg == (TUMBLE_DIV - 16'd1));
  assign settle_done = tick && (settle_reg == (SETTLE_TICKS - 8'd1));

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; button activity during SETTLE is deliberately ignored.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (btn_rise)    state_next = ST_ROLL;
      ST_ROLL:   if (!level)      state_next = ST_SETTLE;
      ST_SETTLE: if (settle_done) state_next = ST_IDLE;
      default:                    state_next = ST_IDLE;
    endcase
  end

  // Per-state datapath control: divider, settle counter, dice redraw, result latch.
  always_comb begin
    div_next    = div_reg;
    settle_next = settle_reg;
    die_a_next  = die_a_reg;
    die_b_next  = die_b_reg;
    finish      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // Divider held at zero so the first redraw lands a full period after entry.
        div_next    = 16'd0;
        settle_next = 8'd0;
      end
      ST_ROLL: begin
        div_next = tick ? 16'd0 : div_reg + 16'd1;
        if (tick) begin
          die_a_next = face_map(lfsr_reg[2:0]);
          die_b_next = face_map(lfsr_reg[5:3]);
        end
        if (!level) settle_next = 8'd0;
      end
      ST_SETTLE: begin
        div_next = tick ? 16'd0 : div_reg + 16'd1;
        if (tick) begin
          die_a_next  = face_map(lfsr_reg[2:0]);
          die_b_next  = face_map(lfsr_reg[5:3]);
          settle_next = settle_reg + 8'd1;
          finish      = settle_done;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; the LFSR runs in every state, flags only move on finish.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_prev_reg <= 1'b0;
      div_reg        <= 16'd0;
      settle_reg     <= 8'd0;
      lfsr_reg       <= LFSR_SEED;
      die_a_reg      <= '0;
      die_b_reg      <= '0;
      sum_reg        <= 4'd0;
      drei_reg       <= 1'b0;
      double_reg     <= 1'b0;
      valid_reg      <= 1'b0;
    end else begin
      level_prev_reg <= level;
      div_reg        <= div_next;
      settle_reg     <= settle_next;
      lfsr_reg       <= lfsr_step(lfsr_reg);
      die_a_reg      <= die_a_next;
      die_b_reg      <= die_b_next;
      valid_reg      <= finish;
      if (finish) begin
        sum_reg    <= {1'b0, die_a_next} + {1'b0, die_b_next};
        drei_reg   <= (die_a_next == 3'd3) || (die_b_next == 3'd3);
        double_reg <= (die_a_next == die_b_next) && (die_a_next != 3'd0);
      end
    end
  end

  // Moore outputs.
  always_comb begin
    rolling = (state_reg != ST_IDLE);
  end

  assign die_a_o        = die_a_reg;
  assign die_b_o        = die_b_reg;
  assign sum_o          = sum_reg;
  assign drei_o         = drei_reg;
  assign double_o       = double_reg;
  assign rolling_o      = rolling;
  assign result_valid_o = valid_reg;

endmodule
